// File: rtl/sipo.sv
`timescale 1ns/1ps
// sipo: serial-in, parallel-out shift register.
// One bit of `d` is captured on every rising edge of `clk`; the whole
// register is presented on `q`. SHIFT_LEFT selects which end `d` enters.
// `q` is driven straight from the register, so there is no combinational
// path from `d` to `q`.
module sipo #(
    parameter int WIDTH      = 4,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Next register contents; the bit leaving the exit end is dropped.
    logic [WIDTH-1:0] q_next;

    // Select the shift direction: entry at bit 0 (left) or bit WIDTH-1 (right).
    always_comb begin
        q_next = q;
        if (SHIFT_LEFT) begin
            q_next = {q[WIDTH-2:0], d};
        end else begin
            q_next = {d, q[WIDTH-1:1]};
        end
    end

    // Shift on every rising edge; asynchronous reset clears all stages at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_sipo.sv
`timescale 1ns/1ps
// Directed testbench for sipo: three instances share clock, reset and
// serial input (4-bit left, 4-bit right, 8-bit left). Inputs change 1 ns
// after the rising edge and outputs are sampled at that same point.
module tb_sipo;

    logic       clk;
    logic       rst;
    logic       d;
    logic [3:0] q4;
    logic [3:0] q4r;
    logic [7:0] q8;

    int checks;
    int failures;

    sipo #(.WIDTH(4), .SHIFT_LEFT(1'b1)) u_left4 (.clk(clk), .rst(rst), .d(d), .q(q4));
    sipo #(.WIDTH(4), .SHIFT_LEFT(1'b0)) u_right4 (.clk(clk), .rst(rst), .d(d), .q(q4r));
    sipo #(.WIDTH(8), .SHIFT_LEFT(1'b1)) u_left8 (.clk(clk), .rst(rst), .d(d), .q(q8));

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one bit ahead of the next rising edge, then settle past the edge.
    task automatic shift_bit(input logic b);
        d = b;
        @(posedge clk);
        #1;
    endtask

    // Reset between edges, release, and leave d at a known 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        d = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        // Hold reset for 20 ns with d unknown; q must stay zero throughout.
        rst = 1'b1;
        d = 1'bx;
        for (int i = 0; i < 8; i++) begin
            #2.5;
            checks++;
            if (q4 !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold step=%0d q=%b expected=%b", i, q4, 4'b0000);
            end
        end
        // Release between edges; nothing moves before the first edge.
        @(posedge clk);
        #1;
        d = 1'b1;
        rst = 1'b0;
        #2;
        checks++;
        if (q8 !== 8'h00) begin
            failures++;
            $display("FAIL release_before_edge q8=%h expected=%h", q8, 8'h00);
        end
        #2;
        // Build q=1011, then assert reset between edges.
        for (int i = 0; i < 4; i++) begin
            shift_bit((i == 1) ? 1'b0 : 1'b1);
            checks++;
            if (q4 !== exp_seq[i]) begin
                failures++;
                $display("FAIL build_1011 edge=%0d q=%b expected=%b", i + 1, q4, exp_seq[i]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL async_clear q=%b expected=%b", q4, 4'b0000);
        end
        d = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic_and_overflow();
        logic       bits    [6];
        logic [3:0] exp_seq [6];
        bits    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_seq = '{4'b0001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0100};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            shift_bit(bits[i]);
            checks++;
            if (q4 !== exp_seq[i]) begin
                failures++;
                $display("FAIL shift_left4 edge=%0d q=%b expected=%b", i + 1, q4, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic       bits    [4];
        logic [3:0] exp_seq [4];
        bits    = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        do_reset();
        shift_bit(1'b1);
        shift_bit(1'b1);
        checks++;
        if (q4 !== 4'b0011) begin
            failures++;
            $display("FAIL mid_partial q=%b expected=%b", q4, 4'b0011);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL mid_clear q=%b expected=%b", q4, 4'b0000);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_bit(bits[i]);
            checks++;
            if (q4 !== exp_seq[i]) begin
                failures++;
                $display("FAIL mid_restart edge=%0d q=%b expected=%b", i + 1, q4, exp_seq[i]);
            end
        end
    endtask

    task automatic test_direction();
        logic       bits    [4];
        logic [3:0] exp_seq [4];
        bits    = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_seq = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            shift_bit(bits[i]);
            checks++;
            if (q4r !== exp_seq[i]) begin
                failures++;
                $display("FAIL shift_right4 edge=%0d q=%b expected=%b", i + 1, q4r, exp_seq[i]);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] word;
        logic [7:0] exp_q;
        word = 8'hA5;
        exp_q = 8'h00;
        do_reset();
        checks++;
        if (q8 !== 8'h00) begin
            failures++;
            $display("FAIL w8_after_reset q=%h expected=%h", q8, 8'h00);
        end
        for (int i = 7; i >= 0; i--) begin
            shift_bit(word[i]);
            exp_q = {exp_q[6:0], word[i]};
            checks++;
            if (q8 !== exp_q) begin
                failures++;
                $display("FAIL w8_shift bit=%0d q=%h expected=%h", i, q8, exp_q);
            end
        end
        checks++;
        if (q8 !== 8'hA5) begin
            failures++;
            $display("FAIL w8_word q=%h expected=%h", q8, 8'hA5);
        end
    endtask

    task automatic test_d_between_edges();
        do_reset();
        // d pulses high between edges but is low at the edge: only 0 captured.
        #1;
        d = 1'b1;
        #2;
        d = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL d_glitch q=%b expected=%b", q4, 4'b0000);
        end
        // d low between edges but high at the edge: 1 captured.
        d = 1'b0;
        #2;
        d = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (q4 !== 4'b0001) begin
            failures++;
            $display("FAIL d_late q=%b expected=%b", q4, 4'b0001);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        d = 1'b0;
        test_reset();
        test_basic_and_overflow();
        test_reset_mid_word();
        test_direction();
        test_width8();
        test_d_between_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo.md
Name: sipo

Overview:
- Serial-in, parallel-out shift register with a single serial data input and a parallel output, 4 bits wide by default.
- One new bit is captured on every rising clock edge, and the full register contents are visible on the parallel output at all times.
- Used as a generic deserialiser stage: the upstream drives one bit per cycle, and the downstream samples `q` when the desired number of bits has been shifted in.

Parameters:
- WIDTH, 4, number of register stages and width of `q`; legal range 2..64.
- SHIFT_LEFT, 1, shift direction. 1: `d` enters at bit 0 and data moves toward the MSB. 0: `d` enters at bit WIDTH-1 and data moves toward the LSB.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high; clears all stages.
- d    input  1  serial data input, sampled on every rising edge of `clk` while `rst` is low.
- q    output WIDTH  parallel register contents; a direct register output with no combinational path from `d`.

Behaviour:
- Reset:
  - `rst` high forces `q` to all zeros immediately, with no clock edge required.
  - `q` holds zero for as long as `rst` stays high; clock edges and `d` are ignored during reset.
- Reset release:
  - Deassertion is asynchronous.
  - The first shift occurs on the first rising edge of `clk` at which `rst` is low.
  - The upstream must drive `d` to a known value before that edge. Otherwise the sampled unknown propagates through `q` for WIDTH cycles. No internal masking is required.
- Shift operation, SHIFT_LEFT=1:
  - Each rising edge: q <= {q[WIDTH-2:0], d}.
  - Oldest bit is `q[WIDTH-1]`; newest bit is `q[0]`.
- Shift operation, SHIFT_LEFT=0:
  - Each rising edge: q <= {d, q[WIDTH-1:1]}.
  - Newest bit is `q[WIDTH-1]`.
- Latency:
  - A bit presented on `d` appears in the entry stage one edge later.
  - It reaches the far end after WIDTH edges.
  - After WIDTH consecutive edges, `q` holds the last WIDTH serial bits, with the first-shifted bit at the exit end.
- No enable input:
  - The register shifts on every edge.
  - The bit shifted out of the exit end is discarded.
  - There is no full/valid flag; the downstream counts cycles itself.
- Reset mid-stream: asserting `rst` between edges clears `q` at once, and the partial word is lost. After release, shifting restarts from zero contents.
- `d` changing between edges has no effect until the next rising edge; only the value at the edge is captured.
- The block contains no other state, no state machine, and no output logic beyond the register itself.

Test Plan:
- Async reset: hold `rst`=1 for 20 ns with `clk` toggling every 5 ns and `d` unknown -> `q`=4'b0000 throughout. Assert `rst` between edges with `q`=4'b1011 -> `q`=4'b0000 within the same time step, before any clock edge.
- Basic shift (WIDTH=4, SHIFT_LEFT=1): release reset, then drive `d`=1,1,0,1 on successive edges -> `q`=0001, 0011, 0110, 1101 after edges 1-4.
- Overflow/discard: continue from 1101 and shift in 0,0 -> `q`=1010, then 0100. MSB bits shifted out are lost.
- Reset mid-word: after shifting 1,1 (`q`=0011), pulse `rst` for 3 ns, then shift 1,0,1,1 -> `q`=0001, 0010, 0101, 1011.
- Direction (SHIFT_LEFT=0): from reset, shift 1,1,0,1 -> `q`=1000, 1100, 0110, 1011.
- Width (WIDTH=8): shift 8'hA5 MSB-first -> `q`=8'hA5 after exactly 8 edges; `q`=8'h00 before the first edge after reset release.
